prog_scheduler: RTL and testbench

Parametrised round-robin program scheduler for the multiprogrammed processor. Tracks up to NUM_PROGS runnable programs in a bitmask, selects the running program, preempts it on a time quantum, and hands over via a request/acknowledge handshake with the CPU context-save logic. It is the generalised successor of the fixed 10-program scheduler: parametrised in program count and quantum, with yield, preemption and a context-switch handshake.

---
 rtl/prog_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_prog_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_scheduler.sv
// ---------------------------------------------------------------------------
// prog_scheduler
//
// Round-robin program scheduler. Keeps a bitmask of runnable programs, picks
// the running program and hands the CPU over through a request/acknowledge
// handshake with the context-save logic.
//
// Optional feature macro: SCHED_QUANTUM_EN
//   defined   -> a quantum counter preempts the running program after QUANTUM
//                RUN cycles.
//   undefined -> no counter is built; scheduling is cooperative (halt/yield).
//
// Handshake: switch_req/next_index are raised by the scheduler and held
// stable until switch_ack is sampled high at a rising edge while in SWITCH;
// on that edge the transfer completes and switch_req drops. switch_ack seen
// in any other state is ignored.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   set_prog    in   mark set_index runnable
//   set_index   in   program to mark runnable (>= NUM_PROGS ignored)
//   halt        in   current program finished; drop it from scheduling
//   yield       in   current program gives up the CPU
//   switch_ack  in   CPU has saved the old context and loaded next_index
//   progIndex   out  current program index
//   running     out  high while in RUN
//   switch_req  out  context switch requested
//   next_index  out  program to switch to (valid while switch_req is high)
//   runnable    out  runnable bitmask
//   state_dbg   out  FSM state (0 IDLE, 1 RUN, 2 SWITCH) for observation
// ---------------------------------------------------------------------------
module prog_scheduler #(
    parameter int NUM_PROGS = 10,
    parameter int IDX_W     = 4,
    parameter int QUANTUM   = 64,
    parameter int QW        = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 set_prog,
    input  logic [IDX_W-1:0]     set_index,
    input  logic                 halt,
    input  logic                 yield,
    input  logic                 switch_ack,
    output logic [IDX_W-1:0]     progIndex,
    output logic                 running,
    output logic                 switch_req,
    output logic [IDX_W-1:0]     next_index,
    output logic [NUM_PROGS-1:0] runnable,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    // Elaboration-time parameter sanity checks.
    if (NUM_PROGS < 2 || NUM_PROGS > 16 || (1 << IDX_W) < NUM_PROGS) begin : g_bad_progs
        $error("prog_scheduler: NUM_PROGS/IDX_W out of range");
    end
    if (QUANTUM < 2 || QW < 1 || (QUANTUM - 1) >= (1 << QW)) begin : g_bad_quantum
        $error("prog_scheduler: QUANTUM/QW out of range");
    end

    state_t               state_q;
    logic [IDX_W-1:0]     prog_q;
    logic [IDX_W-1:0]     next_q;
    logic                 switch_req_q;
    logic                 running_q;
    logic [NUM_PROGS-1:0] runnable_q;
    logic [NUM_PROGS-1:0] runnable_d;
    logic                 expire;

    // -----------------------------------------------------------------------
    // Selection: walk the registered mask from prog_q+1 upward with wrap.
    // sel_run skips prog_q itself; sel_idle accepts prog_q as the final
    // candidate so a lone program can be re-selected after going idle.
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] sel_run;
    logic [IDX_W-1:0] sel_idle;
    logic             found_run;
    logic             found_idle;

    always_comb begin
        int   cand;
        logic cand_bit;
        sel_run    = prog_q;
        sel_idle   = prog_q;
        found_run  = 1'b0;
        found_idle = 1'b0;
        cand       = 0;
        cand_bit   = 1'b0;
        for (int i = 1; i <= NUM_PROGS; i++) begin
            cand = int'(prog_q) + i;
            if (cand >= NUM_PROGS) cand = cand - NUM_PROGS;
            cand_bit = 1'b0;
            for (int j = 0; j < NUM_PROGS; j++) begin
                if (cand == j) cand_bit = runnable_q[j];
            end
            if (cand_bit && !found_idle) begin
                found_idle = 1'b1;
                sel_idle   = IDX_W'(cand);
            end
            if (cand_bit && !found_run && i < NUM_PROGS) begin
                found_run = 1'b1;
                sel_run   = IDX_W'(cand);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Quantum counter (optional).
    // -----------------------------------------------------------------------
`ifdef SCHED_QUANTUM_EN
    logic [QW-1:0] counter_q;
    logic [QW-1:0] counter_d;

    assign expire = (state_q == ST_RUN) && (counter_q == '0);

    // Reload whenever not running or on any trigger: leaving RUN needs a fresh
    // value on re-entry, and staying in RUN after yield/expiry restarts the
    // slice. Otherwise count down once per RUN cycle.
    always_comb begin
        counter_d = QW'(QUANTUM - 1);
        if (state_q == ST_RUN && !(halt || yield || expire)) begin
            counter_d = counter_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) counter_q <= QW'(QUANTUM - 1);
        else          counter_q <= counter_d;
    end
`else
    assign expire = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Runnable mask. The halt clear is applied first so a simultaneous
    // set_prog of the same index leaves the bit set.
    // -----------------------------------------------------------------------
    always_comb begin
        runnable_d = runnable_q;
        if (state_q == ST_RUN && halt) begin
            for (int j = 0; j < NUM_PROGS; j++) begin
                if (prog_q == IDX_W'(j)) runnable_d[j] = 1'b0;
            end
        end
        if (set_prog) begin
            for (int j = 0; j < NUM_PROGS; j++) begin
                if (set_index == IDX_W'(j)) runnable_d[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) runnable_q <= '0;
        else          runnable_q <= runnable_d;
    end

    // -----------------------------------------------------------------------
    // Scheduler FSM with registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            prog_q       <= '0;
            next_q       <= '0;
            switch_req_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|runnable_q) begin
                        state_q      <= ST_SWITCH;
                        switch_req_q <= 1'b1;
                        next_q       <= sel_idle;
                    end
                end
                ST_RUN: begin
                    // halt has priority over yield and expiry.
                    if (halt) begin
                        running_q <= 1'b0;
                        if (found_run) begin
                            state_q      <= ST_SWITCH;
                            switch_req_q <= 1'b1;
                            next_q       <= sel_run;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if ((yield || expire) && found_run) begin
                        state_q      <= ST_SWITCH;
                        running_q    <= 1'b0;
                        switch_req_q <= 1'b1;
                        next_q       <= sel_run;
                    end
                end
                ST_SWITCH: begin
                    if (switch_ack) begin
                        state_q      <= ST_RUN;
                        prog_q       <= next_q;
                        switch_req_q <= 1'b0;
                        running_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    switch_req_q <= 1'b0;
                    running_q    <= 1'b0;
                end
            endcase
        end
    end

    assign progIndex  = prog_q;
    assign running    = running_q;
    assign switch_req = switch_req_q;
    assign next_index = next_q;
    assign runnable   = runnable_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_prog_scheduler.sv
// ---------------------------------------------------------------------------
// tb_prog_scheduler: table-driven vectors for single-cycle behaviour, hand
// sequences for multi-cycle corners, and a scoreboard that checks next_index
// each time switch_req rises.
// ---------------------------------------------------------------------------
module tb_prog_scheduler;

    localparam int NUM_PROGS = 10;
    localparam int IDX_W     = 4;
    localparam int QUANTUM   = 64;
    localparam int QW        = 8;

    // ---------------- clock / reset ----------------
    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 set_prog = 1'b0;
    logic [IDX_W-1:0]     set_index = '0;
    logic                 halt = 1'b0;
    logic                 yield = 1'b0;
    logic                 switch_ack = 1'b0;
    logic [IDX_W-1:0]     progIndex;
    logic                 running;
    logic                 switch_req;
    logic [IDX_W-1:0]     next_index;
    logic [NUM_PROGS-1:0] runnable;
    logic [1:0]           state_dbg;

    always #5 clock = ~clock;

    prog_scheduler #(
        .NUM_PROGS(NUM_PROGS),
        .IDX_W    (IDX_W),
        .QUANTUM  (QUANTUM),
        .QW       (QW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .set_prog   (set_prog),
        .set_index  (set_index),
        .halt       (halt),
        .yield      (yield),
        .switch_ack (switch_ack),
        .progIndex  (progIndex),
        .running    (running),
        .switch_req (switch_req),
        .next_index (next_index),
        .runnable   (runnable),
        .state_dbg  (state_dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [IDX_W-1:0] exp_q[$];
    logic [IDX_W-1:0] exp_v;
    logic             req_seen = 1'b0;

    always @(negedge clock) begin
        if (!reset_n) begin
            req_seen = 1'b0;
        end else begin
            if (switch_req && !req_seen) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_switch_req: got next_index 0x%0h expected no request at %0t",
                             next_index, $time);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("sb_next_index", 32'(next_index), 32'(exp_v));
                end
            end
            req_seen = switch_req;
        end
    end

    // ---------------- driver ----------------
    // Apply inputs for one cycle; return 1 time unit after the rising edge.
    task automatic step(input logic s, input int idx, input logic h, input logic y, input logic a);
        set_prog   = s;
        set_index  = IDX_W'(idx);
        halt       = h;
        yield      = y;
        switch_ack = a;
        @(posedge clock);
        #1;
        set_prog   = 1'b0;
        set_index  = '0;
        halt       = 1'b0;
        yield      = 1'b0;
        switch_ack = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic                 s;
        logic [IDX_W-1:0]     idx;
        logic                 h;
        logic                 y;
        logic                 a;
        logic [IDX_W-1:0]     e_prog;
        logic                 e_run;
        logic                 e_req;
        logic [IDX_W-1:0]     e_next;
        logic [NUM_PROGS-1:0] e_mask;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input int s, input int idx, input int h, input int y, input int a,
                                    input int e_prog, input int e_run, input int e_req,
                                    input int e_next, input int e_mask);
        vec_t v;
        v.s      = 1'(s);
        v.idx    = IDX_W'(idx);
        v.h      = 1'(h);
        v.y      = 1'(y);
        v.a      = 1'(a);
        v.e_prog = IDX_W'(e_prog);
        v.e_run  = 1'(e_run);
        v.e_req  = 1'(e_req);
        v.e_next = IDX_W'(e_next);
        v.e_mask = NUM_PROGS'(e_mask);
        vecs.push_back(v);
    endfunction

    initial begin
        logic prev_req;
        vec_t v;

        //        s idx h y a   prog run req next mask
        add_vec(1,  3, 0,0,0,   0,  0,  0,  0, 'h008); // set 3, IDLE sees old mask
        add_vec(0,  0, 0,0,0,   0,  0,  1,  3, 'h008); // IDLE -> SWITCH to 3
        add_vec(0,  0, 0,0,1,   3,  1,  0,  0, 'h008); // ack -> RUN 3
        add_vec(1,  1, 0,0,0,   3,  1,  0,  0, 'h00A);
        add_vec(1,  7, 0,0,0,   3,  1,  0,  0, 'h08A);
        add_vec(1, 12, 0,0,0,   3,  1,  0,  0, 'h08A); // out-of-range set ignored
        add_vec(0,  0, 0,1,0,   3,  0,  1,  7, 'h08A); // yield: 3 -> 7
        add_vec(0,  0, 0,1,0,   3,  0,  1,  7, 'h08A); // yield ignored in SWITCH
        add_vec(0,  0, 1,0,0,   3,  0,  1,  7, 'h08A); // halt ignored in SWITCH
        add_vec(0,  0, 0,0,1,   7,  1,  0,  0, 'h08A);
        add_vec(0,  0, 0,0,1,   7,  1,  0,  0, 'h08A); // ack outside SWITCH ignored
        add_vec(0,  0, 1,1,0,   7,  0,  1,  1, 'h00A); // halt+yield = halt, wrap to 1
        add_vec(0,  0, 0,0,1,   1,  1,  0,  0, 'h00A);
        add_vec(0,  0, 0,1,0,   1,  0,  1,  3, 'h00A);
        add_vec(0,  0, 0,0,1,   3,  1,  0,  0, 'h00A);
        add_vec(0,  0, 1,0,0,   3,  0,  1,  1, 'h002); // halt 3 -> 1 (wrap)
        add_vec(0,  0, 0,0,1,   1,  1,  0,  0, 'h002);
        add_vec(0,  0, 0,1,0,   1,  1,  0,  0, 'h002); // sole program yields: stays RUN
        add_vec(0,  0, 1,0,0,   1,  0,  0,  0, 'h000); // sole program halts: IDLE
        add_vec(0,  0, 0,0,0,   1,  0,  0,  0, 'h000);

        // reset
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_progIndex",  32'(progIndex),  0);
        check("rst_running",    32'(running),    0);
        check("rst_switch_req", 32'(switch_req), 0);
        check("rst_next_index", 32'(next_index), 0);
        check("rst_runnable",   32'(runnable),   0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // table-driven vectors
        prev_req = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.e_req && !prev_req) exp_q.push_back(v.e_next);
            prev_req = v.e_req;
            step(v.s, int'(v.idx), v.h, v.y, v.a);
            check($sformatf("v%0d_progIndex", i),  32'(progIndex),  32'(v.e_prog));
            check($sformatf("v%0d_running", i),    32'(running),    32'(v.e_run));
            check($sformatf("v%0d_switch_req", i), 32'(switch_req), 32'(v.e_req));
            check($sformatf("v%0d_runnable", i),   32'(runnable),   32'(v.e_mask));
            if (v.e_req) check($sformatf("v%0d_next_index", i), 32'(next_index), 32'(v.e_next));
        end

        // set wins over halt on the same index; handshake held stable
        step(1, 2, 0, 0, 0);
        check("sw_mask_a", 32'(runnable), 'h004);
        exp_q.push_back(IDX_W'(2));
        step(1, 4, 0, 0, 0);
        check("sw_req_a",  32'(switch_req), 1);
        check("sw_mask_b", 32'(runnable),   'h014);
        step(0, 0, 0, 0, 1);
        check("sw_prog_2", 32'(progIndex), 2);
        check("sw_run_2",  32'(running),   1);
        exp_q.push_back(IDX_W'(4));
        step(1, 2, 1, 0, 0);
        check("sw_mask_set_wins", 32'(runnable),   'h014);
        check("sw_req_b",         32'(switch_req), 1);
        check("sw_next_4",        32'(next_index), 4);
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 0, 0);
            check($sformatf("hold%0d_req", k),  32'(switch_req), 1);
            check($sformatf("hold%0d_next", k), 32'(next_index), 4);
        end
        step(0, 0, 0, 0, 1);
        check("sw_prog_4", 32'(progIndex),  4);
        check("sw_req_c",  32'(switch_req), 0);

        // asynchronous reset in the middle of SWITCH
        exp_q.push_back(IDX_W'(2));
        step(0, 0, 0, 1, 0);
        check("mid_req", 32'(switch_req), 1);
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_switch_req", 32'(switch_req), 0);
        check("arst_progIndex",  32'(progIndex),  0);
        check("arst_runnable",   32'(runnable),   0);
        check("arst_running",    32'(running),    0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

`ifdef SCHED_QUANTUM_EN
        // timer preemption: runnable {1,3,7}, running 3
        step(1, 3, 0, 0, 0);
        exp_q.push_back(IDX_W'(3));
        step(1, 1, 0, 0, 0);
        step(1, 7, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("q_prog_3", 32'(progIndex), 3);
        repeat (QUANTUM - 1) step(0, 0, 0, 0, 0);
        check("q_no_early_req", 32'(switch_req), 0);
        exp_q.push_back(IDX_W'(7));
        step(0, 0, 0, 0, 0);
        check("q_req_7",  32'(switch_req), 1);
        check("q_next_7", 32'(next_index), 7);
        step(0, 0, 0, 0, 1);
        check("q_prog_7", 32'(progIndex), 7);
        repeat (QUANTUM - 1) step(0, 0, 0, 0, 0);
        check("q_no_early_req2", 32'(switch_req), 0);
        exp_q.push_back(IDX_W'(1));
        step(0, 0, 0, 0, 0);
        check("q_req_1",  32'(switch_req), 1);
        check("q_next_1", 32'(next_index), 1);
        step(0, 0, 0, 0, 1);
        check("q_prog_1", 32'(progIndex), 1);
`else
        // cooperative only: no preemption however long a program runs
        step(1, 3, 0, 0, 0);
        exp_q.push_back(IDX_W'(3));
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("coop_prog_3", 32'(progIndex), 3);
        repeat (1000) step(0, 0, 0, 0, 0);
        check("coop_no_req",  32'(switch_req), 0);
        check("coop_running", 32'(running),    1);
        check("coop_prog",    32'(progIndex),  3);
`endif

        @(negedge clock);
        #1;
        check("sb_queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
